// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types for the FIFO write arbiter (data byte type, arbiter state encoding)
package fifo_arb_pkg;
  typedef logic [7:0] byte_t;
  typedef enum logic {IDLE, OWN} arb_state_e;
endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: combinational round-robin pick; ports req_valid/rr_ptr in, any/idx out (first valid index at or after rr_ptr, wrapping)
module fifo_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] rr_ptr,
  output logic          any,
  output logic [IW-1:0] idx
);
  always_comb begin
    any = |req_valid;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % N]) idx = IW'((int'(rr_ptr) + k) % N);
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port; ports clk/rst, req_valid/req_data/req_ready per producer, fifo_read tap in, fifo_write_ctrl/fifo_write_data to FIFO, grant_valid/grant_id/level status out
import fifo_arb_pkg::*;
module fifo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ENTRIES = 4,
  parameter int BURST = 2,
  localparam int IW = $clog2(NUM_REQ),
  localparam int LW = $clog2(ENTRIES) + 1,
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_read,
  output logic                 fifo_write_ctrl,
  output logic [7:0]           fifo_write_data,
  output logic                 grant_valid,
  output logic [IW-1:0]        grant_id,
  output logic [LW-1:0]        level
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, owner_inc, pick_ptr, pick_idx;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] level_q, level_d;
  logic own, space, wr, rd, rel, pick_any, take;
  byte_t owner_data;
  fifo_rr_pick #(.N(NUM_REQ)) u_pick (
    .req_valid(req_valid),
    .rr_ptr(pick_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );
  assign own = state_q == OWN;
  assign space = level_q != LW'(ENTRIES);
  assign owner_data = req_data[int'(owner_q) * 8 +: 8];
  assign owner_inc = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
  assign wr = own & req_valid[owner_q] & space;
  assign rd = fifo_read & (level_q != '0);
  // a dropped valid releases immediately; otherwise release on the last beat of the burst
  assign rel = own & (~req_valid[owner_q] | (wr & (beat_q == BW'(BURST - 1))));
  // on release the pick already sees the advanced pointer, so handoff has no bubble
  assign pick_ptr = rel ? owner_inc : ptr_q;
  assign take = (~own | rel) & pick_any;
  assign req_ready = (own & space) ? NUM_REQ'(1) << owner_q : '0;
  assign fifo_write_ctrl = wr;
  assign fifo_write_data = wr ? owner_data : '0;
  assign grant_valid = own;
  assign grant_id = owner_q;
  assign level = level_q;
  always_comb begin
    state_d = ((own & ~rel) | take) ? OWN : IDLE;
    owner_d = take ? pick_idx : owner_q;
    beat_d = (~own | rel) ? '0 : wr ? beat_q + BW'(1) : beat_q;
    ptr_d = rel ? owner_inc : ptr_q;
    level_d = level_q + LW'(wr) - LW'(rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      beat_q <= '0;
      ptr_q <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q <= beat_d;
      ptr_q <= ptr_d;
      level_q <= level_d;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid;
  logic [31:0] req_data;
  logic [3:0] req_ready;
  logic fifo_read;
  logic fifo_write_ctrl;
  logic [7:0] fifo_write_data;
  logic grant_valid;
  logic [1:0] grant_id;
  logic [2:0] level;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pq[4][$];
  logic [3:0] en;
  logic rd_v;

  fifo_write_arbiter dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_read(fifo_read),
    .fifo_write_ctrl(fifo_write_ctrl),
    .fifo_write_data(fifo_write_data),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .level(level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_write_ctrl === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wdata unexpected write got=%02h", fifo_write_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (fifo_write_data !== e) begin
          bad++;
          $display("FAIL wdata got=%02h exp=%02h", fifo_write_data, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = en[i] && pq[i].size() > 0;
      req_data[i*8 +: 8] = pq[i].size() > 0 ? pq[i][0] : 8'h00;
    end
    fifo_read = rd_v;
  endtask

  // producers retire a beat only when valid and ready were both high before the edge
  task automatic cyc();
    logic [3:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) void'(pq[i].pop_front());
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 4'h0;
    rd_v = 1'b0;
    for (int i = 0; i < 4; i++) pq[i].delete();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = 4'h0;
    rd_v = 1'b0;
    drive();
    @(negedge clk);
    cyc();
    chk("rst_level", 32'(level), 0);
    chk("rst_grant_valid", 32'(grant_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wctrl", 32'(fifo_write_ctrl), 0);
    chk("rst_wdata", 32'(fifo_write_data), 0);
    rst = 1'b0;
    // single producer, three beats across a burst boundary
    pq[0] = '{8'hA0, 8'hA1, 8'hA2};
    en = 4'b0001;
    exp_q = '{8'hA0, 8'hA1, 8'hA2};
    cyc();
    chk("s1_idle", 32'(grant_valid), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s1_stream", 32'(fifo_write_ctrl), 1);
    end
    cyc();
    chk("s1_level", 32'(level), 3);
    cyc();
    do_reset();
    // all four producers, FIFO fills and req2 stalls
    pq[0] = '{8'h10, 8'h11};
    pq[1] = '{8'h20, 8'h21};
    pq[2] = '{8'h30, 8'h31};
    pq[3] = '{8'h40, 8'h41};
    en = 4'hF;
    exp_q = '{8'h10, 8'h11, 8'h20, 8'h21};
    for (int i = 0; i < 6; i++) cyc();
    chk("s2_level", 32'(level), 4);
    chk("s2_ready", 32'(req_ready), 0);
    chk("s2_grant_id", 32'(grant_id), 2);
    chk("s2_grant_valid", 32'(grant_valid), 1);
    cyc();
    chk("s2_stall_wctrl", 32'(fifo_write_ctrl), 0);
    chk("s2_stall_id", 32'(grant_id), 2);
    // one read frees a slot that req2 uses the next cycle
    rd_v = 1'b1;
    exp_q.push_back(8'h30);
    cyc();
    rd_v = 1'b0;
    chk("s3_pre_level", 32'(level), 4);
    cyc();
    chk("s3_level_dec", 32'(level), 3);
    chk("s3_wctrl", 32'(fifo_write_ctrl), 1);
    chk("s3_ready", 32'(req_ready), 4'b0100);
    cyc();
    chk("s3_level_full", 32'(level), 4);
    do_reset();
    // owner drops valid at beat 0, grant passes to req3 without a write
    pq[1] = '{8'h50, 8'h51};
    pq[3] = '{8'h70};
    en = 4'b1010;
    exp_q = '{8'h70};
    cyc();
    en = 4'b1000;
    cyc();
    chk("s4_drop_wctrl", 32'(fifo_write_ctrl), 0);
    chk("s4_drop_id", 32'(grant_id), 1);
    cyc();
    chk("s4_new_id", 32'(grant_id), 3);
    cyc();
    chk("s4_level", 32'(level), 1);
    cyc();
    do_reset();
    // reads while empty are ignored; read plus write leaves level unchanged
    rd_v = 1'b1;
    cyc();
    rd_v = 1'b0;
    cyc();
    chk("s5_empty_read", 32'(level), 0);
    pq[0] = '{8'h80, 8'h81, 8'h82};
    en = 4'b0001;
    exp_q = '{8'h80, 8'h81, 8'h82};
    cyc();
    cyc();
    cyc();
    rd_v = 1'b1;
    cyc();
    chk("s5_level_pre", 32'(level), 2);
    rd_v = 1'b0;
    cyc();
    chk("s5_rw_level", 32'(level), 2);
    cyc();
    do_reset();
    // reset mid-burst at level 3, then lowest valid index wins
    pq[0] = '{8'h90, 8'h91, 8'h92, 8'h93};
    en = 4'b0001;
    exp_q = '{8'h90, 8'h91, 8'h92, 8'h93};
    for (int i = 0; i < 5; i++) cyc();
    chk("s6_pre_level", 32'(level), 3);
    rst = 1'b1;
    pq[1] = '{8'hB1};
    pq[3] = '{8'hD1};
    en = 4'b1010;
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hD1);
    cyc();
    chk("s6_level", 32'(level), 0);
    chk("s6_grant_valid", 32'(grant_valid), 0);
    chk("s6_wctrl", 32'(fifo_write_ctrl), 0);
    rst = 1'b0;
    cyc();
    chk("s6_first_id", 32'(grant_id), 1);
    cyc();
    cyc();
    chk("s6_second_id", 32'(grant_id), 3);
    cyc();
    chk("s6_end_level", 32'(level), 2);
    cyc();
    cyc();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-side arbiter that shares one 8-bit `fifo` instance among `NUM_REQ` producers. It owns the FIFO's `in_write_ctrl` and `in_write_data`, and grants producers in bursts of up to `BURST` beats. Flow control comes from a private occupancy counter that tracks writes issued and reads observed, so the FIFO's registered status flags are never used. It sits directly in front of the `fifo` write port; the consumer drives the FIFO read strobe, and the arbiter taps that same strobe.

## Interface
- `NUM_REQ`, default 4, number of producers (≥2).
- `ENTRIES`, default 4, depth of the attached FIFO; must equal that FIFO's `ENTRIES`.
- `BURST`, default 2, maximum beats per grant (≥1).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `req_valid`  in  `NUM_REQ`  per-producer data valid.
- `req_data`  in  `NUM_REQ`×8  per-producer data byte.
- `req_ready`  out  `NUM_REQ`  per-producer accept. A beat transfers when valid and ready are both high.
- `fifo_read`  in  1  copy of the FIFO `in_read_ctrl`.
- `fifo_write_ctrl`  out  1  to FIFO `in_write_ctrl`.
- `fifo_write_data`  out  8  to FIFO `in_write_data`.
- `grant_valid`  out  1  high while in OWN.
- `grant_id`  out  `$clog2(NUM_REQ)`  current owner index.
- `level`  out  `$clog2(ENTRIES)+1`  tracked FIFO occupancy.

## Operation
- **State machine.** Two states.
  - IDLE: no owner.
  - OWN: one producer is the owner.
  - Registered state: `owner`, `beat` counter (0..`BURST`-1), `rr_ptr`.
- **Pick function.** Returns the first index with `req_valid` high, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- **IDLE.**
  - If any `req_valid` is high: go to OWN with `owner` = pick, `beat` = 0.
  - No write occurs in an IDLE cycle, so arbitration costs one bubble from IDLE only.
- **OWN, signals.**
  - `space` = (`level` != `ENTRIES`).
  - `req_ready[owner]` = `space`; all other `req_ready` bits are 0.
  - `fifo_write_ctrl` = `req_valid[owner]` & `space`.
  - `fifo_write_data` = `req_data[owner]`; drive 0 when not writing.
- **OWN, transitions.**
  - Write with `beat` < `BURST`-1: increment `beat`.
  - Write with `beat` = `BURST`-1: release.
  - `req_valid[owner]` = 0: release; no write occurs in that cycle.
  - Valid but `space` = 0: stall. Keep the grant, `beat` unchanged.
- **Release.**
  - Set `rr_ptr` = `owner`+1 (mod `NUM_REQ`).
  - Compute pick using that new pointer and the current `req_valid`.
  - If any request is valid: stay in OWN with the new owner and `beat` = 0, with no bubble. The same producer may win again if it is the only one valid.
  - Otherwise go to IDLE.
- **Occupancy counter.**
  - `rd` = `fifo_read` & (`level` != 0). Reads while empty are ignored.
  - `level` <= `level` + `fifo_write_ctrl` − `rd`.
  - There is no same-cycle read bypass: a slot freed by a read is usable the following cycle.
- **Reset.**
  - State: IDLE, `level` = 0, `rr_ptr` = 0, `owner` = 0, `beat` = 0.
  - Outputs: `req_ready` = 0, `fifo_write_ctrl` = 0, `fifo_write_data` = 0, `grant_valid` = 0, `grant_id` = 0.
  - Reset mid-burst drops the grant with no write in the next cycle. The FIFO must be reset in the same cycle.

## Timing
- `req_ready`, `grant_valid` and `grant_id` depend only on registered state and `level`. They are never combinational from `req_valid`.
- `fifo_write_ctrl` and `fifo_write_data` are combinational from `req_valid[owner]` and `req_data[owner]` through a single mux.
- The FIFO samples the write on the same edge on which the arbiter updates `level` and `beat`.
- Latency: valid in IDLE at cycle n → first write at cycle n+1.
- Sustained throughput: 1 beat/cycle while `space` = 1, across handoffs.
- `level` never exceeds `ENTRIES` and never underflows.

## Structure
- Package `fifo_arb_pkg`:
  - `byte_t` (`logic [7:0]`).
  - `arb_state_e` {IDLE, OWN}.
- Sub-module `fifo_rr_pick`: purely combinational.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: `any`, `idx`.
  - Used for both the IDLE pick and the release pick.

## Test plan
All scenarios use `NUM_REQ`=4, `ENTRIES`=4, `BURST`=2.
1. After reset, only req0 is valid with A0, A1, A2 → IDLE at cycle 1; writes A0, A1, A2 at cycles 2–4 with no bubble at the burst boundary; `level` = 3.
2. req0–req3 valid continuously, no reads → writes r0, r0, r1, r1; then `level` = 4, req2 owns with `req_ready` = 0, stalled; `grant_id` = 2.
3. Continue from scenario 2 with a 1-cycle `fifo_read` pulse → `level` 4→3; req2 writes on the next cycle; `level` = 4 again.
4. req1 owns, `beat` = 0, and drops valid while req3 is valid → no write in the drop cycle; `grant_id` = 3 on the next cycle.
5. `fifo_read` at `level` 0 → `level` stays 0. `fifo_read` plus a write at `level` 2 → `level` stays 2.
6. `rst` asserted mid-burst at `level` 3 → next cycle `level` = 0, `grant_valid` = 0, `fifo_write_ctrl` = 0; after release, the first grant goes to the lowest valid index.
